// File: rtl/alu_iter_param.sv
// Parametrised multi-cycle ALU: ADD/SUB/CMP in one edge; MUL (shift-add) and DIV (restoring) iterate WIDTH edges.
// Valid/ready on both sides; a result is held in DONE until the consumer takes it.
module alu_iter_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] rem_out,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_CMP = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             accept;
    logic             single;
    logic             iter_last;
    logic             mul_r;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [WIDTH-1:0] quo, rem, divisor;
    logic [WIDTH-1:0] acc_nxt, quo_nxt, rem_nxt;
    logic [WIDTH:0]   shifted, diff;

    logic [WIDTH-1:0] sc_alu, sc_rem;
    logic             sc_dz;

    assign accept    = in_valid && in_ready;
    assign single    = !((op == OP_MUL) || ((op == OP_DIV) && (rt != '0)));
    assign iter_last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // in_ready is gated by reset so nothing is accepted while it is held
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !reset;
                if (in_valid && !reset) begin
                    state_nxt = single ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (iter_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration step for each engine
    always_comb begin
        acc_nxt = acc + (mplier[0] ? mcand : '0);
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            rem_nxt = diff[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        sc_alu = '0;
        sc_rem = '0;
        sc_dz  = 1'b0;
        case (op)
            OP_ADD: sc_alu = rs + rt;
            OP_SUB: sc_alu = rs - rt;
            OP_DIV: begin
                sc_alu = '1;
                sc_rem = rs;
                sc_dz  = 1'b1;
            end
            OP_CMP: sc_alu = {{(WIDTH-3){1'b0}}, (rs > rt), (rs == rt), (rs < rt)};
            default: sc_alu = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_r       <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            quo         <= '0;
            rem         <= '0;
            divisor     <= '0;
            alu_out     <= '0;
            rem_out     <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            mul_r   <= (op == OP_MUL);
            cnt     <= '0;
            acc     <= '0;
            mcand   <= rs;
            mplier  <= rt;
            quo     <= rs;
            rem     <= '0;
            divisor <= rt;
            if (single) begin
                alu_out     <= sc_alu;
                rem_out     <= sc_rem;
                div_by_zero <= sc_dz;
            end
        end else if (state == BUSY) begin
            cnt <= cnt + CW'(1);
            if (mul_r) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end else begin
                rem <= rem_nxt;
                quo <= quo_nxt;
            end
            // results land on the same edge that enters DONE
            if (iter_last) begin
                alu_out     <= mul_r ? acc_nxt : quo_nxt;
                rem_out     <= mul_r ? '0 : rem_nxt;
                div_by_zero <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_iter_param.sv
module tb_alu_iter_param;
    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] alu;
        logic [31:0] rem;
        logic        dz;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
    logic        in_ready8, out_valid8, dz8;
    logic [2:0]  op8 = '0;
    logic [7:0]  rs8 = '0, rt8 = '0, alu8, rem8;

    logic        in_valid16 = 1'b0, out_ready16 = 1'b1;
    logic        in_ready16, out_valid16, dz16;
    logic [2:0]  op16 = '0;
    logic [15:0] rs16 = '0, rt16 = '0, alu16, rem16;

    int n_cmp = 0;
    int n_fail = 0;
    vec_t sb8[$];
    vec_t sb16[$];
    vec_t tbl[12];

    alu_iter_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .rs(rs8), .rt(rt8), .out_valid(out_valid8), .out_ready(out_ready8),
        .alu_out(alu8), .rem_out(rem8), .div_by_zero(dz8)
    );

    alu_iter_param #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
        .op(op16), .rs(rs16), .rt(rt16), .out_valid(out_valid16), .out_ready(out_ready16),
        .alu_out(alu16), .rem_out(rem16), .div_by_zero(dz16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run8(input vec_t v, input string name);
        int   lat;
        vec_t e;
        sb8.push_back(v);
        @(negedge clk);
        op8 = v.op; rs8 = v.rs[7:0]; rt8 = v.rt[7:0]; in_valid8 = 1'b1;
        check({name, " in_ready"}, {31'd0, in_ready8}, 32'd1);
        @(posedge clk); #1;
        // scramble inputs after capture; the result must not change
        in_valid8 = 1'b0; rs8 = ~rs8; rt8 = ~rt8; op8 = 3'd7;
        lat = 1;
        while (!out_valid8 && lat < 100) begin
            check({name, " busy in_ready"}, {31'd0, in_ready8}, 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        e = sb8.pop_front();
        check({name, " alu_out"}, {24'd0, alu8}, e.alu);
        check({name, " rem_out"}, {24'd0, rem8}, e.rem);
        check({name, " div_by_zero"}, {31'd0, dz8}, {31'd0, e.dz});
        check({name, " latency"}, lat, e.lat);
        check({name, " done in_ready"}, {31'd0, in_ready8}, 32'd0);
        if (out_ready8) begin
            @(posedge clk); #1;
            check({name, " back to idle"}, {31'd0, out_valid8}, 32'd0);
        end
    endtask

    task automatic run16(input vec_t v, input string name);
        int   lat;
        vec_t e;
        sb16.push_back(v);
        @(negedge clk);
        op16 = v.op; rs16 = v.rs[15:0]; rt16 = v.rt[15:0]; in_valid16 = 1'b1;
        check({name, " in_ready"}, {31'd0, in_ready16}, 32'd1);
        @(posedge clk); #1;
        in_valid16 = 1'b0; rs16 = ~rs16; rt16 = ~rt16; op16 = 3'd7;
        lat = 1;
        while (!out_valid16 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb16.pop_front();
        check({name, " alu_out"}, {16'd0, alu16}, e.alu);
        check({name, " rem_out"}, {16'd0, rem16}, e.rem);
        check({name, " div_by_zero"}, {31'd0, dz16}, {31'd0, e.dz});
        check({name, " latency"}, lat, e.lat);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t v;
        tbl[0]  = '{3'd0, 200, 100, 44,  0,  1'b0, 1};
        tbl[1]  = '{3'd1, 5,   7,   254, 0,  1'b0, 1};
        tbl[2]  = '{3'd4, 9,   9,   2,   0,  1'b0, 1};
        tbl[3]  = '{3'd4, 10,  3,   4,   0,  1'b0, 1};
        tbl[4]  = '{3'd4, 3,   10,  1,   0,  1'b0, 1};
        tbl[5]  = '{3'd2, 13,  11,  143, 0,  1'b0, 9};
        tbl[6]  = '{3'd2, 255, 255, 1,   0,  1'b0, 9};
        tbl[7]  = '{3'd3, 200, 7,   28,  4,  1'b0, 9};
        tbl[8]  = '{3'd3, 77,  0,   255, 77, 1'b1, 1};
        tbl[9]  = '{3'd5, 3,   4,   0,   0,  1'b0, 1};
        tbl[10] = '{3'd3, 5,   9,   0,   5,  1'b0, 9};
        tbl[11] = '{3'd2, 0,   200, 0,   0,  1'b0, 9};

        #1;
        check("reset out_valid", {31'd0, out_valid8}, 32'd0);
        check("reset in_ready", {31'd0, in_ready8}, 32'd0);
        check("reset alu_out", {24'd0, alu8}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        check("release in_ready", {31'd0, in_ready8}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            run8(tbl[i], $sformatf("vec%0d", i));
        end

        // backpressure after a MUL
        out_ready8 = 1'b0;
        v = '{3'd2, 13, 11, 143, 0, 1'b0, 9};
        run8(v, "bp_mul");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp out_valid", {31'd0, out_valid8}, 32'd1);
            check("bp alu_out", {24'd0, alu8}, 32'd143);
            check("bp in_ready", {31'd0, in_ready8}, 32'd0);
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        check("bp release out_valid", {31'd0, out_valid8}, 32'd0);
        check("bp release in_ready", {31'd0, in_ready8}, 32'd1);

        // asynchronous reset in the middle of a MUL
        @(negedge clk);
        op8 = 3'd2; rs8 = 8'd13; rt8 = 8'd11; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midreset out_valid", {31'd0, out_valid8}, 32'd0);
        check("midreset alu_out", {24'd0, alu8}, 32'd0);
        check("midreset rem_out", {24'd0, rem8}, 32'd0);
        check("midreset in_ready", {31'd0, in_ready8}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post reset in_ready", {31'd0, in_ready8}, 32'd1);
        v = '{3'd0, 1, 1, 2, 0, 1'b0, 1};
        run8(v, "add_after_reset");

        v = '{3'd2, 300, 300, 24464, 0, 1'b0, 17};
        run16(v, "w16_mul");
        v = '{3'd3, 65535, 255, 257, 0, 1'b0, 17};
        run16(v, "w16_div");
        v = '{3'd3, 1234, 0, 65535, 1234, 1'b1, 1};
        run16(v, "w16_div0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
